// File: rtl/seg7_frame_reader_if.sv
// Display-bus sampling inputs and frame handshake outputs of seg7_frame_reader.
interface seg7_frame_reader_if #(
   parameter int NUM_DIGITS = 4
);
   logic [6:0]              seg_in;
   logic [NUM_DIGITS-1:0]   dig_sel;
   logic                    sample_en;
   logic [4*NUM_DIGITS-1:0] bcd_out;
   logic [NUM_DIGITS-1:0]   digit_err;
   logic                    frame_valid;
   logic                    frame_ready;
   logic                    sel_err;

   modport master (
      output seg_in, dig_sel, sample_en, frame_ready,
      input  bcd_out, digit_err, frame_valid, sel_err
   );

   modport slave (
      input  seg_in, dig_sel, sample_en, frame_ready,
      output bcd_out, digit_err, frame_valid, sel_err
   );
endinterface

// File: rtl/seg7_frame_reader.sv
// Reconstructs the BCD value shown on a multiplexed seven-segment bus and
// offers each stable, changed frame through a valid/ready handshake.
module seg7_frame_reader #(
   parameter int NUM_DIGITS = 4,
   parameter int STABLE_CNT = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   seg7_frame_reader_if.slave bus
);
   localparam logic [3:0] STABLE_LIM = 4'(STABLE_CNT);

   typedef enum logic [0:0] {ST_ACQ = 1'b0, ST_OFFER = 1'b1} state_t;

   // Returns {err, code}; unknown patterns give code F with err set.
   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'h7E:   r = {1'b0, 4'h0};
         7'h30:   r = {1'b0, 4'h1};
         7'h6D:   r = {1'b0, 4'h2};
         7'h79:   r = {1'b0, 4'h3};
         7'h33:   r = {1'b0, 4'h4};
         7'h5B:   r = {1'b0, 4'h5};
         7'h5F:   r = {1'b0, 4'h6};
         7'h70:   r = {1'b0, 4'h7};
         7'h7F:   r = {1'b0, 4'h8};
         7'h7B:   r = {1'b0, 4'h9};
         default: r = {1'b1, 4'hF};
      endcase
      return r;
   endfunction

   function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
      logic seen;
      logic multi;
      seen  = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (v[i]) begin
            multi = multi | seen;
            seen  = 1'b1;
         end else begin
            multi = multi;
         end
      end
      return seen & ~multi;
   endfunction

   logic [NUM_DIGITS-1:0][3:0] code_q, code_d;
   logic [NUM_DIGITS-1:0][3:0] cnt_q, cnt_d;
   logic [NUM_DIGITS-1:0]      err_q, err_d;
   logic [NUM_DIGITS-1:0]      lock_q, lock_d;
   logic [4*NUM_DIGITS-1:0]    bcd_q, bcd_d;
   logic [NUM_DIGITS-1:0]      derr_q, derr_d;
   logic [5*NUM_DIGITS-1:0]    last_q, last_d;
   logic                       first_q, first_d;
   logic                       sel_err_q, sel_err_d;
   state_t                     state_q, state_d;

   logic [4:0]                 dec_s;
   logic                       sel_ok_s;
   logic                       accept_s;
   logic                       all_locked_s;
   logic [5*NUM_DIGITS-1:0]    snap_s;

   assign dec_s        = seg_decode(bus.seg_in);
   assign sel_ok_s     = is_onehot(bus.dig_sel);
   assign accept_s     = bus.sample_en & sel_ok_s;
   assign all_locked_s = &lock_q;
   assign snap_s       = {code_q, err_q};

   // Per-digit stability tracking; a changed pattern restarts the count at 1.
   always_comb begin
      code_d    = code_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      lock_d    = lock_q;
      sel_err_d = bus.sample_en & ~sel_ok_s;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (accept_s && bus.dig_sel[i]) begin
            if ((dec_s[3:0] == code_q[i]) && (dec_s[4] == err_q[i])) begin
               if (cnt_q[i] < STABLE_LIM) begin
                  cnt_d[i] = cnt_q[i] + 4'd1;
               end else begin
                  cnt_d[i] = cnt_q[i];
               end
            end else begin
               code_d[i] = dec_s[3:0];
               err_d[i]  = dec_s[4];
               cnt_d[i]  = 4'd1;
            end
         end else begin
            cnt_d[i] = cnt_q[i];
         end
         lock_d[i] = (cnt_d[i] == STABLE_LIM);
      end
   end

   // Frame offer FSM: the snapshot is frozen on entry to OFFER until accepted.
   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      derr_d  = derr_q;
      last_d  = last_q;
      first_d = first_q;
      case (state_q)
         ST_ACQ: begin
            if (all_locked_s && (first_q || (snap_s != last_q))) begin
               state_d = ST_OFFER;
               bcd_d   = code_q;
               derr_d  = err_q;
            end else begin
               state_d = ST_ACQ;
            end
         end
         ST_OFFER: begin
            if (bus.frame_ready) begin
               state_d = ST_ACQ;
               last_d  = {bcd_q, derr_q};
               first_d = 1'b0;
            end else begin
               state_d = ST_OFFER;
            end
         end
         default: begin
            state_d = ST_ACQ;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q    <= {NUM_DIGITS{4'h0}};
         cnt_q     <= {NUM_DIGITS{4'h0}};
         err_q     <= {NUM_DIGITS{1'b0}};
         lock_q    <= {NUM_DIGITS{1'b0}};
         bcd_q     <= {(4*NUM_DIGITS){1'b0}};
         derr_q    <= {NUM_DIGITS{1'b0}};
         last_q    <= {(5*NUM_DIGITS){1'b0}};
         first_q   <= 1'b1;
         sel_err_q <= 1'b0;
         state_q   <= ST_ACQ;
      end else begin
         code_q    <= code_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         lock_q    <= lock_d;
         bcd_q     <= bcd_d;
         derr_q    <= derr_d;
         last_q    <= last_d;
         first_q   <= first_d;
         sel_err_q <= sel_err_d;
         state_q   <= state_d;
      end
   end

   assign bus.bcd_out     = bcd_q;
   assign bus.digit_err   = derr_q;
   assign bus.frame_valid = (state_q == ST_OFFER);
   assign bus.sel_err     = sel_err_q;
endmodule

// File: tb/tb_seg7_frame_reader.sv
// Directed, table-driven bench for seg7_frame_reader.
module tb_seg7_frame_reader;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   seg7_frame_reader_if #(.NUM_DIGITS(4)) bus_if ();

   seg7_frame_reader #(.NUM_DIGITS(4), .STABLE_CNT(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [27:0] pats;    // {digit3, digit2, digit1, digit0} segment patterns
      logic [15:0] exp_bcd;
      logic [3:0]  exp_err;
   } frame_vec_t;

   frame_vec_t vecs [5];

   localparam logic [27:0] P1234 = {7'h30, 7'h6D, 7'h79, 7'h33};
   localparam logic [27:0] P5678 = {7'h5B, 7'h5F, 7'h70, 7'h7F};
   localparam logic [27:0] P0954 = {7'h7E, 7'h7B, 7'h5B, 7'h33};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sample(input logic [3:0] sel, input logic [6:0] pat);
      bus_if.sample_en = 1'b1;
      bus_if.dig_sel   = sel;
      bus_if.seg_in    = pat;
      tick();
      bus_if.sample_en = 1'b0;
      bus_if.dig_sel   = 4'b0000;
   endtask

   task automatic scan_rounds(input logic [27:0] pats, input int n);
      logic [3:0] sel;
      for (int r = 0; r < n; r++) begin
         for (int d = 3; d >= 0; d--) begin
            sel = 4'b0001 << d;
            sample(sel, pats[7*d +: 7]);
         end
      end
   endtask

   task automatic accept();
      bus_if.frame_ready = 1'b1;
      tick();
      bus_if.frame_ready = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      vecs[0] = '{{7'h7B, 7'h7E, 7'h30, 7'h6D}, 16'h9012, 4'b0000};
      vecs[1] = '{{7'h79, 7'h00, 7'h7E, 7'h30}, 16'h3F01, 4'b0100};
      vecs[2] = '{{7'h01, 7'h7E, 7'h7D, 7'h33}, 16'hF0F4, 4'b1010};
      vecs[3] = '{{7'h6D, 7'h30, 7'h70, 7'h7F}, 16'h2178, 4'b0000};
      vecs[4] = '{{7'h7E, 7'h7B, 7'h5B, 7'h5F}, 16'h0956, 4'b0000};

      rst_n              = 1'b0;
      bus_if.seg_in      = 7'h00;
      bus_if.dig_sel     = 4'b0000;
      bus_if.sample_en   = 1'b0;
      bus_if.frame_ready = 1'b0;
      #12;
      chk("rst_valid", 16'(bus_if.frame_valid), 16'd0);
      chk("rst_bcd", bus_if.bcd_out, 16'h0000);
      chk("rst_err", 16'(bus_if.digit_err), 16'd0);
      chk("rst_sel_err", 16'(bus_if.sel_err), 16'd0);
      rst_n = 1'b1;
      tick();

      // First frame: offered one cycle after the locking sample.
      scan_rounds(P1234, 3);
      chk("lock_edge_valid", 16'(bus_if.frame_valid), 16'd0);
      tick();
      chk("lock_valid", 16'(bus_if.frame_valid), 16'd1);
      chk("lock_bcd", bus_if.bcd_out, 16'h1234);
      chk("lock_err", 16'(bus_if.digit_err), 16'd0);

      // Backpressure: display changes while stalled must not touch the offer.
      scan_rounds(P5678, 3);
      chk("stall_valid", 16'(bus_if.frame_valid), 16'd1);
      chk("stall_bcd", bus_if.bcd_out, 16'h1234);
      tick();
      accept();
      chk("xfer_low", 16'(bus_if.frame_valid), 16'd0);
      tick();
      chk("next_valid", 16'(bus_if.frame_valid), 16'd1);
      chk("next_bcd", bus_if.bcd_out, 16'h5678);
      accept();
      chk("next_xfer_low", 16'(bus_if.frame_valid), 16'd0);

      // Unchanged display must not produce a duplicate frame.
      for (int r = 0; r < 10; r++) begin
         scan_rounds(P5678, 1);
         chk($sformatf("nodup_r%0d", r), 16'(bus_if.frame_valid), 16'd0);
      end

      for (int v = 0; v < 5; v++) begin
         scan_rounds(vecs[v].pats, 3);
         chk($sformatf("vec%0d_edge_valid", v), 16'(bus_if.frame_valid), 16'd0);
         tick();
         chk($sformatf("vec%0d_valid", v), 16'(bus_if.frame_valid), 16'd1);
         chk($sformatf("vec%0d_bcd", v), bus_if.bcd_out, vecs[v].exp_bcd);
         chk($sformatf("vec%0d_err", v), 16'(bus_if.digit_err), 16'(vecs[v].exp_err));
         accept();
         chk($sformatf("vec%0d_xfer_low", v), 16'(bus_if.frame_valid), 16'd0);
      end

      // Digit 0 goes 6 -> 4 with a glitch and rejected selects in between.
      sample(4'b1000, 7'h7E);
      sample(4'b0100, 7'h7B);
      sample(4'b0010, 7'h5B);
      sample(4'b0001, 7'h33);
      chk("glitch_a_valid", 16'(bus_if.frame_valid), 16'd0);
      sample(4'b0011, 7'h33);
      chk("selerr_multi", 16'(bus_if.sel_err), 16'd1);
      sample(4'b0000, 7'h33);
      chk("selerr_zero", 16'(bus_if.sel_err), 16'd1);
      tick();
      chk("selerr_clear", 16'(bus_if.sel_err), 16'd0);
      bus_if.dig_sel = 4'b0011;
      tick();
      chk("selerr_no_en", 16'(bus_if.sel_err), 16'd0);
      sample(4'b0001, 7'h33);
      chk("glitch_b_valid", 16'(bus_if.frame_valid), 16'd0);
      sample(4'b0001, 7'h5B);
      chk("glitch_c_valid", 16'(bus_if.frame_valid), 16'd0);
      sample(4'b0001, 7'h33);
      sample(4'b0001, 7'h33);
      tick();
      chk("glitch_d_valid", 16'(bus_if.frame_valid), 16'd0);
      sample(4'b0001, 7'h33);
      chk("glitch_edge_valid", 16'(bus_if.frame_valid), 16'd0);
      tick();
      chk("glitch_valid", 16'(bus_if.frame_valid), 16'd1);
      chk("glitch_bcd", bus_if.bcd_out, 16'h0954);

      // Asynchronous reset while offering drops the frame immediately.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 16'(bus_if.frame_valid), 16'd0);
      chk("arst_bcd", bus_if.bcd_out, 16'h0000);
      chk("arst_err", 16'(bus_if.digit_err), 16'd0);
      chk("arst_sel_err", 16'(bus_if.sel_err), 16'd0);
      rst_n = 1'b1;
      tick();
      scan_rounds(P0954, 2);
      tick();
      chk("relock_partial_valid", 16'(bus_if.frame_valid), 16'd0);
      scan_rounds(P0954, 1);
      tick();
      chk("relock_valid", 16'(bus_if.frame_valid), 16'd1);
      chk("relock_bcd", bus_if.bcd_out, 16'h0954);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
